uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
- Physical UART transmitter directly downstream of the transmit DMA/FIFO stage.
- Consumes the single-cycle byte valid pulse and 8-bit data from that stage and exposes the ready flag that stage samples before each FIFO read.
- Serialises each accepted byte as one 8N1-style frame on the TX pin: start bit, LSB-first data, optional parity, 1 or 2 stop bits.

Parameters:
- P_BAUD_DIV, 434, clock cycles per bit (50 MHz / 115200); legal range >= 2.
- P_DATA_WIDTH, 8, data bits per frame; legal range 5..8.
- P_PARITY, 0, 0 = none, 1 = odd, 2 = even.
- P_STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- i_clk  in  1  system clock; the only clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_tx_valid  in  1  byte strobe from upstream; a single-cycle pulse is sufficient.
- i_tx_data  in  P_DATA_WIDTH  byte to send; sampled only on accept.
- o_tx_ready  out  1  high only in IDLE; upstream may issue i_tx_valid while it is high.
- o_uart_tx  out  1  serial line; idles high.
- o_frame_done  out  1  one-cycle pulse on the cycle the final stop bit completes.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset values: o_uart_tx = 1, o_tx_ready = 0, o_frame_done = 0. State = IDLE; baud counter, bit counter and shift register = 0.
- First clock edge after i_rst deasserts: o_tx_ready = 1.
- Registered outputs: all outputs are registered; there is no combinational path from the inputs.
- Accept: at a clock edge where i_tx_valid && o_tx_ready, latch i_tx_data into the shift register.
  - On the same edge: state -> START, o_tx_ready -> 0, o_uart_tx -> 0.
  - Latency from accept edge to start bit on the line: 1 cycle.
- Valid while busy: an i_tx_valid arriving while o_tx_ready = 0 is ignored and the byte is lost. Upstream must gate on ready.
- Baud counter: counts 0..P_BAUD_DIV-1 in every non-IDLE state. bit_end = (cnt == P_BAUD_DIV-1). The counter wraps to 0 at bit_end. Each bit holds exactly P_BAUD_DIV cycles.
- States:
  - IDLE: line = 1, ready = 1.
  - START: line = 0. At bit_end -> DATA.
  - DATA: line = shreg[0]. At bit_end, shift right and increment bit_cnt. After bit P_DATA_WIDTH-1, go to PARITY if P_PARITY != 0, else STOP.
  - PARITY: line = parity bit. At bit_end -> STOP.
  - STOP: line = 1. At bit_end, if stop_cnt == P_STOP_BITS-1 -> IDLE; else increment stop_cnt and remain in STOP.
- Parity computation:
  - Even: XOR-reduce of the latched byte.
  - Odd: inverse of that XOR-reduce.
  - Computed from the byte latched at accept, not from the shifting register.
- Frame end:
  - On the edge leaving STOP: o_frame_done = 1 for exactly 1 cycle, o_tx_ready = 1 on the same edge, line stays 1.
- Frame timing:
  - Frame length = (1 + P_DATA_WIDTH + (P_PARITY != 0) + P_STOP_BITS) * P_BAUD_DIV cycles.
  - Back-to-back frames: at least 1 IDLE cycle separates them, so the final stop bit is effectively P_BAUD_DIV + 1 cycles. This is allowed by UART framing.
- Reset mid-frame: at the next edge, return to reset values; the partial frame is abandoned and the line goes high immediately.
- Simultaneous accept with reset: reset wins; the byte is dropped.
- Width rule: data widths below 8 use i_tx_data[P_DATA_WIDTH-1:0]; the upper bits are ignored.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding constants: ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP.
  - parity encoding constants: PAR_NONE = 0, PAR_ODD = 1, PAR_EVEN = 2.
  - the default baud divisor constant.
- One sub-module: uart_baud_tick.
  - Enable-gated modulo-P_BAUD_DIV counter producing bit_end.
  - To be reused by the receive side.
- The FSM, shift register and parity logic stay in the top module.

Test Plan:
- Basic frame: P_BAUD_DIV = 4, no parity, 1 stop; pulse valid with 8'hA5 -> line 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. o_tx_ready low for 40 cycles. o_frame_done pulses on cycle 40 after accept.
- Parity: 8'hA5 with P_PARITY = 2 -> parity bit 0. Same byte with P_PARITY = 1 -> parity bit 1. Frame = 44 cycles; P_STOP_BITS = 2 -> 48 cycles.
- Busy drop: pulse valid with 8'h3C, then pulse valid with 8'hFF 10 cycles later -> only 8'h3C is transmitted; no second start bit appears.
- Back-to-back: upstream FIFO stage preloaded with 8'h01, 8'h80, 8'h55 -> three frames decode correctly, each separated by a stop length of at least 5 cycles (DIV = 4). Three o_frame_done pulses.
- Reset mid-frame: assert i_rst for 1 cycle during data bit 3 of 8'hF0 -> line = 1 and ready = 0 on the next edge, ready = 1 one edge after release. A following 8'h0F is sent intact.
- Post-reset idle: hold i_rst for 5 cycles, then release with no valid -> o_uart_tx stays 1 and o_frame_done stays 0 for 100 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path and its future receive-side
// counterpart: FSM state encoding, parity mode encoding, default baud divisor
// and a counter-width helper.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // 50 MHz system clock / 115200 baud
    localparam int C_BAUD_DIV_DEFAULT = 434;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int counter_width(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Enable-gated modulo-P_BAUD_DIV counter. While enabled it counts
// 0..P_BAUD_DIV-1 and flags the last cycle of each bit period; while disabled
// it is held at zero so the first enabled cycle always starts a fresh bit.
// Shared between the transmit and receive sides.
//
// Ports:
//   i_clk      system clock
//   i_rst      synchronous active-high reset
//   i_en       count enable (high while a frame is in progress)
//   o_bit_end  high on the final cycle of the current bit period
// -----------------------------------------------------------------------------
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int P_BAUD_DIV = C_BAUD_DIV_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_bit_end
);

    localparam int              CW       = counter_width(P_BAUD_DIV);
    localparam logic [CW-1:0]   CNT_LAST = CW'(P_BAUD_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          at_last;

    assign at_last   = (cnt_q == CNT_LAST);
    assign o_bit_end = i_en && at_last;

    always_comb begin
        cnt_d = cnt_q;
        if (!i_en) begin
            cnt_d = '0;
        end else if (at_last) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
// UART transmitter fed by the transmit DMA/FIFO stage. Accepts one data word
// per frame on a single-cycle valid strobe while ready is high and sends it as
// start bit, LSB-first data, optional parity and one or two stop bits.
// All outputs come straight from flops.
//
// Ports:
//   i_clk         system clock
//   i_rst         synchronous active-high reset
//   i_tx_valid    word strobe from upstream (single-cycle pulse is enough)
//   i_tx_data     word to send, sampled only on accept
//   o_tx_ready    high only while idle; upstream gates valid on it
//   o_uart_tx     serial line, idles high
//   o_frame_done  one-cycle pulse as the final stop bit completes
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | line high, ready high, waiting for valid
// ST_START  | start bit (line low)
// ST_DATA   | data bits, LSB first, from shreg[0]
// ST_PARITY | parity bit of the word latched at accept
// ST_STOP   | stop bit(s), line high; stop_cnt counts extra stop bits
// -----------------------------------------------------------------------------
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int P_BAUD_DIV   = C_BAUD_DIV_DEFAULT,
    parameter int P_DATA_WIDTH = 8,
    parameter int P_PARITY     = PAR_NONE,
    parameter int P_STOP_BITS  = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_tx_valid,
    input  logic [P_DATA_WIDTH-1:0] i_tx_data,
    output logic                    o_tx_ready,
    output logic                    o_uart_tx,
    output logic                    o_frame_done
);

    localparam int            BW        = counter_width(P_DATA_WIDTH);
    localparam logic [BW-1:0] BIT_LAST  = BW'(P_DATA_WIDTH - 1);
    localparam logic          STOP_LAST = 1'(P_STOP_BITS - 1);

    uart_state_e             state_q,    state_d;
    logic [P_DATA_WIDTH-1:0] shreg_q,    shreg_d;
    logic [BW-1:0]           bit_cnt_q,  bit_cnt_d;
    logic                    stop_cnt_q, stop_cnt_d;
    logic                    parity_q,   parity_d;
    logic                    tx_q,       tx_d;
    logic                    ready_q,    ready_d;
    logic                    done_q,     done_d;

    logic bit_end;
    logic accept;
    logic data_xor;

    uart_baud_tick #(
        .P_BAUD_DIV (P_BAUD_DIV)
    ) u_baud_tick (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_en      (state_q != ST_IDLE),
        .o_bit_end (bit_end)
    );

    assign accept   = i_tx_valid && ready_q;
    assign data_xor = ^i_tx_data;

    // The line register is loaded with the value of the *next* bit, so each
    // transition is computed one cycle ahead, on the bit_end cycle.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        parity_d   = parity_q;
        tx_d       = tx_q;
        ready_d    = ready_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_d       = 1'b1;
                ready_d    = 1'b1;
                bit_cnt_d  = '0;
                stop_cnt_d = 1'b0;
                if (accept) begin
                    shreg_d  = i_tx_data;
                    // Parity is frozen here because the shift register is
                    // consumed as the data bits go out.
                    parity_d = (P_PARITY == PAR_ODD) ? ~data_xor : data_xor;
                    state_d  = ST_START;
                    ready_d  = 1'b0;
                    tx_d     = 1'b0;
                end
            end

            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    tx_d    = shreg_q[0];
                end
            end

            ST_DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        if (P_PARITY != PAR_NONE) begin
                            state_d = ST_PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        tx_d      = shreg_q[1];
                    end
                end
            end

            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end

            ST_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        state_d    = ST_IDLE;
                        stop_cnt_d = 1'b0;
                        ready_d    = 1'b1;
                        done_d     = 1'b1;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
        end
    end

    assign o_tx_ready   = ready_q;
    assign o_uart_tx    = tx_q;
    assign o_frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data = 8'h00;

    always #5 clk = ~clk;

    logic rdy0, line0, done0;
    logic rdy1, line1, done1;
    logic rdy2, line2, done2;

    // Three configurations driven by the same stimulus:
    //   dut0: DIV 4, 8 bits, no parity,   1 stop -> 40 cycles/frame
    //   dut1: DIV 4, 8 bits, even parity, 2 stop -> 48 cycles/frame
    //   dut2: DIV 3, 6 bits, odd parity,  1 stop -> 27 cycles/frame
    uart_tx_serializer #(.P_BAUD_DIV(4), .P_DATA_WIDTH(8), .P_PARITY(PAR_NONE), .P_STOP_BITS(1)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_tx_valid(valid), .i_tx_data(data),
        .o_tx_ready(rdy0), .o_uart_tx(line0), .o_frame_done(done0));
    uart_tx_serializer #(.P_BAUD_DIV(4), .P_DATA_WIDTH(8), .P_PARITY(PAR_EVEN), .P_STOP_BITS(2)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_tx_valid(valid), .i_tx_data(data),
        .o_tx_ready(rdy1), .o_uart_tx(line1), .o_frame_done(done1));
    uart_tx_serializer #(.P_BAUD_DIV(3), .P_DATA_WIDTH(6), .P_PARITY(PAR_ODD), .P_STOP_BITS(1)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_tx_valid(valid), .i_tx_data(data[5:0]),
        .o_tx_ready(rdy2), .o_uart_tx(line2), .o_frame_done(done2));

    logic line_w[3];
    logic rdy_w[3];
    logic done_w[3];
    assign line_w[0] = line0; assign rdy_w[0] = rdy0; assign done_w[0] = done0;
    assign line_w[1] = line1; assign rdy_w[1] = rdy1; assign done_w[1] = done1;
    assign line_w[2] = line2; assign rdy_w[2] = rdy2; assign done_w[2] = done2;

    int div_k[3]  = '{4, 4, 3};
    int w_k[3]    = '{8, 8, 6};
    int par_k[3]  = '{0, 2, 1};
    int stop_k[3] = '{1, 2, 1};

    int checks = 0;
    int errors = 0;

    int   cyc = 0;
    logic rst_seen = 1'b1;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    // Reference model state
    int         q_exp[3][$];
    int         ready_edge[3] = '{0, 0, 0};
    int         mon_pos[3]    = '{-1, -1, -1};
    logic [15:0] exp_f[3];
    logic       frame_bad[3];
    logic       skip[3] = '{1'b0, 1'b0, 1'b0};

    function automatic int flen(input int k);
        return (1 + w_k[k] + ((par_k[k] != 0) ? 1 : 0) + stop_k[k]) * div_k[k];
    endfunction

    // Frame as a list of line levels, one entry per bit period.
    function automatic logic [15:0] build_frame(input int k, input int b);
        logic [15:0] f;
        int          n;
        int          ones;
        f = '1;
        n = 0;
        f[n] = 1'b0;
        n++;
        for (int i = 0; i < w_k[k]; i++) begin
            f[n] = ((b >> i) & 1) != 0;
            n++;
        end
        if (par_k[k] != 0) begin
            ones = $countones(b);
            // even: make total count of ones even; odd: make it odd
            f[n] = (par_k[k] == 2) ? ((ones % 2) == 1) : ((ones % 2) == 0);
            n++;
        end
        return f;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", name, k, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int k = 0; k < 3; k++) begin
                if (rst_seen) begin
                    mon_pos[k] = -1;
                    skip[k]    = 1'b0;
                    q_exp[k].delete();
                    chk("reset_line", k, 32'(line_w[k]), 1);
                    chk("reset_ready", k, 32'(rdy_w[k]), 0);
                    chk("reset_done", k, 32'(done_w[k]), 0);
                end else if (skip[k]) begin
                    if (line_w[k] === 1'b1) skip[k] = 1'b0;
                end else begin
                    if (mon_pos[k] < 0) begin
                        if (done_w[k] !== 1'b0) begin
                            checks++;
                            errors++;
                            $display("FAIL idle_done dut%0d: got %b expected 0 (cycle %0d)", k, done_w[k], cyc);
                        end
                        if (line_w[k] === 1'b0) begin
                            if (q_exp[k].size() == 0) begin
                                checks++;
                                errors++;
                                skip[k] = 1'b1;
                                $display("FAIL unexpected_start dut%0d: got line 0 expected 1 (cycle %0d)", k, cyc);
                            end else begin
                                exp_f[k]     = build_frame(k, q_exp[k].pop_front());
                                mon_pos[k]   = 0;
                                frame_bad[k] = 1'b0;
                            end
                        end
                    end
                    if (mon_pos[k] >= 0) begin
                        if (mon_pos[k] < flen(k)) begin
                            if (line_w[k] !== exp_f[k][mon_pos[k] / div_k[k]] ||
                                rdy_w[k] !== 1'b0 || done_w[k] !== 1'b0) begin
                                frame_bad[k] = 1'b1;
                            end
                            mon_pos[k]++;
                        end else begin
                            chk("frame_bits", k, 32'(frame_bad[k]), 0);
                            chk("frame_done", k, 32'(done_w[k]), 1);
                            chk("ready_after_frame", k, 32'(rdy_w[k]), 1);
                            chk("line_after_frame", k, 32'(line_w[k]), 1);
                            mon_pos[k] = -1;
                        end
                    end
                end
            end
        end
    end

    // Stimulus (always called at a negedge)
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        int e;
        valid = 1'b1;
        data  = b;
        e = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            if (e >= ready_edge[k]) begin
                q_exp[k].push_back(int'(b) & ((1 << w_k[k]) - 1));
                ready_edge[k] = e + flen(k) + 1;
            end
        end
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        tick(n);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) ready_edge[k] = cyc + 2;
    endtask

    task automatic check_ready_all(input string name);
        for (int k = 0; k < 3; k++) chk(name, k, 32'(rdy_w[k]), 1);
    endtask

    function automatic logic all_idle();
        for (int k = 0; k < 3; k++) begin
            if (q_exp[k].size() != 0 || mon_pos[k] >= 0 || cyc + 1 < ready_edge[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic wait_idle(input int limit);
        int n = 0;
        while (!all_idle() && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_time", 0, 32'(all_idle()), 1);
    endtask

    task automatic wait_ready0(input int limit);
        int n = 0;
        while (cyc + 1 < ready_edge[0] && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        logic [7:0] fifo [3];
        int         bad;
        fifo[0] = 8'h01; fifo[1] = 8'h80; fifo[2] = 8'h55;

        @(negedge clk);
        do_reset(3);
        tick(1);
        check_ready_all("ready_after_reset");

        // basic frame / parity variants
        send(8'hA5);
        wait_idle(200);

        // busy drop: second strobe 10 cycles after the first
        send(8'h3C);
        tick(9);
        send(8'hFF);
        wait_idle(200);

        // back-to-back from a preloaded upstream FIFO paced by dut0 readiness
        for (int i = 0; i < 3; i++) begin
            wait_ready0(200);
            send(fifo[i]);
        end
        wait_idle(300);

        // reset during data bit 3 of 8'hF0 (dut0 timing), then 8'h0F intact
        send(8'hF0);
        tick(16);
        do_reset(1);
        tick(1);
        check_ready_all("ready_after_midframe_reset");
        send(8'h0F);
        wait_idle(200);

        // accept coincident with reset: byte dropped
        rst   = 1'b1;
        valid = 1'b1;
        data  = 8'hAA;
        @(negedge clk);
        valid = 1'b0;
        rst   = 1'b0;
        for (int k = 0; k < 3; k++) ready_edge[k] = cyc + 2;
        tick(60);

        // long reset then quiet line
        do_reset(5);
        tick(1);
        check_ready_all("ready_after_long_reset");
        for (int k = 0; k < 3; k++) begin
            bad = 0;
            for (int c = 0; c < 100; c++) begin
                if (line_w[k] !== 1'b1 || done_w[k] !== 1'b0) bad++;
                @(negedge clk);
                k = k;
            end
            chk("idle_quiet", k, 32'(bad), 0);
        end

        // randomized traffic with occasional resets
        repeat (80) begin
            if ($urandom_range(0, 19) == 0) begin
                do_reset($urandom_range(1, 3));
            end else begin
                send(8'($urandom));
            end
            tick($urandom_range(0, 50));
        end
        wait_idle(400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
